// File: rtl/sec32_encoder.sv
// Streaming SEC check-bit generator for 32-bit words feeding a c499 corrector,
// with a 2-entry output buffer. Optional one-shot bit-flip injection: FAULT_INJ_EN.
module sec32_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [7:0]       out_chk,
  output logic [CNT_W-1:0] word_cnt,
  input  logic             inj_req,
  input  logic [5:0]       inj_pos,
  output logic             inj_pending
);

  // Handshake: a word moves on a side in any cycle where valid & ready are both
  // high; valid never waits on ready, and in_ready depends only on registered occupancy.

  function automatic logic [7:0] gen_chk(input logic [31:0] d);
    logic [7:0] c;
    c[0] = d[0] ^ d[4] ^ d[8]  ^ d[12] ^ (^d[23:16]);
    c[1] = d[1] ^ d[5] ^ d[9]  ^ d[13] ^ (^d[31:24]);
    c[2] = d[2] ^ d[6] ^ d[10] ^ d[14] ^ (^d[19:16]) ^ (^d[27:24]);
    c[3] = d[3] ^ d[7] ^ d[11] ^ d[15] ^ (^d[23:20]) ^ (^d[31:28]);
    c[4] = (^d[7:0])  ^ d[16] ^ d[20] ^ d[24] ^ d[28];
    c[5] = (^d[15:8]) ^ d[17] ^ d[21] ^ d[25] ^ d[29];
    c[6] = (^d[3:0])  ^ (^d[11:8])  ^ d[18] ^ d[22] ^ d[26] ^ d[30];
    c[7] = (^d[7:4])  ^ (^d[15:12]) ^ d[19] ^ d[23] ^ d[27] ^ d[31];
    return c;
  endfunction

  logic [1:0]  occ, occ_next;
  logic        rdy_q;
  logic [39:0] ent0, ent1;
  logic [39:0] new_word;
  logic [39:0] flip_mask;
  logic        push, pop;

  assign in_ready  = rdy_q;
  assign out_valid = (occ != 2'd0);
  assign out_data  = ent0[31:0];
  assign out_chk   = ent0[39:32];
  assign push      = in_valid & rdy_q;
  assign pop       = out_valid & out_ready;
  assign new_word  = {gen_chk(in_data), in_data} ^ flip_mask;

`ifdef FAULT_INJ_EN
  logic       pend_q;
  logic [5:0] pos_q;

  // A request in the same cycle as an accept re-arms for the following word.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= 1'b0;
      pos_q  <= 6'd0;
    end else if (inj_req) begin
      pend_q <= 1'b1;
      pos_q  <= inj_pos;
    end else if (push) begin
      pend_q <= 1'b0;
    end
  end

  always_comb begin
    flip_mask = '0;
    if (pend_q && (pos_q < 6'd40)) flip_mask = 40'd1 << pos_q;
  end

  assign inj_pending = pend_q;
`else
  logic unused_inj;
  assign unused_inj  = ^{inj_req, inj_pos};
  assign flip_mask   = '0;
  assign inj_pending = 1'b0;
`endif

  always_comb begin
    occ_next = occ;
    case ({push, pop})
      2'b10:   occ_next = occ + 2'd1;
      2'b01:   occ_next = occ - 2'd1;
      default: occ_next = occ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ      <= 2'd0;
      rdy_q    <= 1'b1;
      ent0     <= '0;
      ent1     <= '0;
      word_cnt <= '0;
    end else begin
      occ      <= occ_next;
      rdy_q    <= (occ_next != 2'd2);
      if (pop) word_cnt <= word_cnt + CNT_W'(1);
      if (pop && occ == 2'd2) ent0 <= ent1;
      // New word lands at the head when the buffer is (or becomes) otherwise empty.
      if (push) begin
        if (occ == 2'd0 || (occ == 2'd1 && pop)) ent0 <= new_word;
        else ent1 <= new_word;
      end
    end
  end

endmodule

// File: tb/tb_sec32_encoder.sv
// Directed bench for sec32_encoder: hand-computed check bits, backpressure,
// streaming, injection (FAULT_INJ_EN), reset and counter wrap.
module tb_sec32_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_chk;
  logic [15:0] word_cnt;
  logic        inj_req;
  logic [5:0]  inj_pos;
  logic        inj_pending;

  logic        in_ready_unused4;
  logic        out_valid_unused4;
  logic [31:0] out_data_unused4;
  logic [7:0]  out_chk_unused4;
  logic        inj_pending_unused4;
  logic [3:0]  word_cnt4;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;
  bit sb_en = 1'b1;
  logic [31:0] exp_q[$];

  sec32_encoder #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_chk(out_chk), .word_cnt(word_cnt),
    .inj_req(inj_req), .inj_pos(inj_pos), .inj_pending(inj_pending)
  );

  sec32_encoder #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_unused4),
    .in_data(in_data), .out_valid(out_valid_unused4), .out_ready(out_ready),
    .out_data(out_data_unused4), .out_chk(out_chk_unused4), .word_cnt(word_cnt4),
    .inj_req(inj_req), .inj_pos(inj_pos), .inj_pending(inj_pending_unused4)
  );

  always #5 clk = ~clk;

  // Reference check bits as parity masks over the data word.
  function automatic logic [7:0] ref_chk(input logic [31:0] d);
    logic [31:0] m [8];
    logic [7:0]  c;
    m[0] = 32'h00FF1111; m[1] = 32'hFF002222; m[2] = 32'h0F0F4444; m[3] = 32'hF0F08888;
    m[4] = 32'h111100FF; m[5] = 32'h2222FF00; m[6] = 32'h44440F0F; m[7] = 32'h8888F0F0;
    for (int k = 0; k < 8; k++) c[k] = ^(d & m[k]);
    return c;
  endfunction

  // c499-style corrector: flip the data bit whose column equals the syndrome.
  function automatic logic [31:0] c499(input logic [31:0] d, input logic [7:0] c);
    logic [7:0]  s;
    logic [31:0] r;
    logic [31:0] one;
    s = c ^ ref_chk(d);
    r = d;
    for (int j = 0; j < 32; j++) begin
      one = 32'd1 << j;
      if (s != 8'd0 && ref_chk(one) == s) r[j] = ~r[j];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: record accepted words, check each popped word in order.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_cnt = 0;
    end else begin
      if (out_valid && out_ready) begin
        exp_cnt++;
        if (sb_en) begin
          if (exp_q.size() == 0) begin
            chk("sb_underflow", 40'd1, 40'd0);
          end else begin
            chk("sb_data", out_data, exp_q[0]);
            chk("sb_chk", out_chk, ref_chk(exp_q[0]));
            void'(exp_q.pop_front());
          end
        end
      end
      if (in_valid && in_ready && sb_en) exp_q.push_back(in_data);
    end
  end

  logic [31:0] vec [9];
  logic [7:0]  vchk [5];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    inj_req = 1'b0; inj_pos = '0;
    vec[0] = 32'h00000000; vec[1] = 32'hFFFFFFFF; vec[2] = 32'h00000001;
    vec[3] = 32'h80000000; vec[4] = 32'h00010000; vec[5] = 32'h12345678;
    vec[6] = 32'hDEADBEEF; vec[7] = 32'hA5A5A5A5; vec[8] = 32'h0F0F0F0F;
    vchk[0] = 8'h00; vchk[1] = 8'h00; vchk[2] = 8'h51; vchk[3] = 8'h8A; vchk[4] = 8'h15;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_chk", out_chk, 8'd0);
    chk("rst_word_cnt", word_cnt, 16'd0);
    chk("rst_inj_pending", inj_pending, 1'b0);

    // T1/T2/T4: continuous stream, one word per cycle, 1-cycle latency.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_data = vec[i];
      tick();
      chk("stream_valid", out_valid, 1'b1);
      chk("stream_in_ready", in_ready, 1'b1);
      chk("stream_data", out_data, vec[i]);
      if (i < 5) chk("hand_chk", out_chk, vchk[i]);
      chk("stream_syndrome", out_chk ^ ref_chk(out_data), 8'd0);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drained", out_valid, 1'b0);
    chk("stream_cnt", word_cnt, 16'd9);

    // T3: backpressure with a full buffer.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hAAAA0001;
    tick();
    chk("bp_a_valid", out_valid, 1'b1);
    chk("bp_a_data", out_data, 32'hAAAA0001);
    chk("bp_a_ready", in_ready, 1'b1);
    in_data = 32'hBBBB0002;
    tick();
    chk("bp_full_ready", in_ready, 1'b0);
    chk("bp_head_a", out_data, 32'hAAAA0001);
    in_data = 32'hCCCC0003;
    tick();
    chk("bp_hold_ready", in_ready, 1'b0);
    chk("bp_hold_data", out_data, 32'hAAAA0001);
    chk("bp_hold_chk", out_chk, ref_chk(32'hAAAA0001));
    out_ready = 1'b1;
    tick();
    chk("bp_head_b", out_data, 32'hBBBB0002);
    chk("bp_ready_again", in_ready, 1'b1);
    tick();
    chk("bp_head_c", out_data, 32'hCCCC0003);
    in_valid = 1'b0;
    tick();
    chk("bp_empty", out_valid, 1'b0);
    chk("bp_cnt", word_cnt, 16'd3);
    chk("bp_cnt_model", word_cnt, 16'(exp_cnt));

    // T5: fault injection request at bit 5 on a zero word.
`ifdef FAULT_INJ_EN
    sb_en = 1'b0;
    inj_req = 1'b1; inj_pos = 6'd5;
    tick();
    inj_req = 1'b0;
    chk("inj_armed", inj_pending, 1'b1);
    in_valid = 1'b1; in_data = 32'h0;
    tick();
    in_valid = 1'b0;
    chk("inj_data", out_data, 32'h00000020);
    chk("inj_chk", out_chk, 8'h00);
    chk("inj_cleared", inj_pending, 1'b0);
    chk("inj_corrected", c499(out_data, out_chk), 32'h0);
    tick();
    sb_en = 1'b1;
`else
    inj_req = 1'b1; inj_pos = 6'd5;
    tick();
    inj_req = 1'b0;
    chk("inj_ignored", inj_pending, 1'b0);
    in_valid = 1'b1; in_data = 32'h0;
    tick();
    in_valid = 1'b0;
    chk("inj_clean_data", out_data, 32'h0);
    chk("inj_clean_chk", out_chk, 8'h00);
    chk("inj_corrected", c499(out_data, out_chk), 32'h0);
    tick();
`endif

    // T6: reset with a full buffer, then wrap of the 4-bit counter.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h11111111;
    tick();
    in_data = 32'h22222222;
    tick();
    chk("t6_full", in_ready, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("t6_rst_valid", out_valid, 1'b0);
    chk("t6_rst_cnt", word_cnt, 16'd0);
    chk("t6_rst_ready", in_ready, 1'b1);
    chk("t6_rst_data", out_data, 32'd0);
    rst = 1'b0;
    tick();
    chk("t6_post_valid", out_valid, 1'b0);
    chk("t6_post_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_data = 32'(i * 32'h01010101);
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("wrap_cnt16", word_cnt, 16'd17);
    chk("wrap_cnt4", word_cnt4, 4'd1);
    chk("sb_empty", 40'(exp_q.size()), 40'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
